memwb_stage: RTL and testbench

//  MEM/WB pipeline register plus write-back path of the xgriscv core; sits directly upstream of the register file.

---
 rtl/memwb_stage_pkg.sv | 33 +++
 rtl/memwb_stage_if.sv | 26 ++
 rtl/memwb_stage_load_align.sv | 45 ++++
 rtl/memwb_stage.sv | 99 +++++++++
 tb/tb_memwb_stage.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/memwb_stage_pkg.sv
// Shared widths, write-back select codes, load funct3 codes and the MEM->WB payload record.
package memwb_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned RFIDX_WIDTH = 5;
    localparam int unsigned ADDR_SIZE   = 32;
    localparam int unsigned INSTRET_W   = 64;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wbsel_e;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef struct packed {
        logic                   regwr;
        logic [RFIDX_WIDTH-1:0] rd;
        wbsel_e                 wbsel;
        logic [2:0]             ldtype;
        logic [ADDR_SIZE-1:0]   pc;
        logic [XLEN-1:0]        alu;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        rdata;
    } wb_payload_t;

endpackage

// File: rtl/memwb_stage_if.sv
// MEM-stage side of the MEM/WB register: retiring instruction payload plus stall/flush control.
interface memwb_stage_if;
    import memwb_stage_pkg::*;

    logic                   mem_valid_i;
    logic                   stall_i;
    logic                   flush_i;
    logic [ADDR_SIZE-1:0]   mem_pc_i;
    logic [RFIDX_WIDTH-1:0] mem_rd_i;
    logic                   mem_regwr_i;
    logic [1:0]             mem_wbsel_i;
    logic [2:0]             mem_ldtype_i;
    logic [XLEN-1:0]        mem_alu_i;
    logic [XLEN-1:0]        mem_imm_i;
    logic [XLEN-1:0]        mem_rdata_i;

    modport master (
        output mem_valid_i, stall_i, flush_i, mem_pc_i, mem_rd_i, mem_regwr_i,
               mem_wbsel_i, mem_ldtype_i, mem_alu_i, mem_imm_i, mem_rdata_i
    );

    modport slave (
        input  mem_valid_i, stall_i, flush_i, mem_pc_i, mem_rd_i, mem_regwr_i,
               mem_wbsel_i, mem_ldtype_i, mem_alu_i, mem_imm_i, mem_rdata_i
    );
endinterface

// File: rtl/memwb_stage_load_align.sv
// Combinational load alignment: picks byte/half/word from the raw memory word and extends it.
module load_align
    import memwb_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      ldtype_i,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata_i[{off_i, 3'b000} +: 8];
        half_sel   = rdata_i[{off_i[1], 4'b0000} +: 16];
        data_o     = rdata_i;
        misalign_o = (off_i != 2'b00);
        unique case (ldtype_i)
            LD_LB: begin
                data_o     = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                misalign_o = 1'b0;
            end
            LD_LBU: begin
                data_o     = {{(XLEN-8){1'b0}}, byte_sel};
                misalign_o = 1'b0;
            end
            LD_LH: begin
                data_o     = {{(XLEN-16){half_sel[15]}}, half_sel};
                misalign_o = off_i[0];
            end
            LD_LHU: begin
                data_o     = {{(XLEN-16){1'b0}}, half_sel};
                misalign_o = off_i[0];
            end
            // lw and every reserved code behave as a full-word load
            default: begin
                data_o     = rdata_i;
                misalign_o = (off_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline register and write-back path driving the register file write port.
// Optional retired-instruction counter enabled by defining XGRISCV_INSTRET_EN.
module memwb_stage
    import memwb_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    memwb_stage_if.slave           mem,
    output logic                   we3,
    output logic [RFIDX_WIDTH-1:0] wa3,
    output logic [XLEN-1:0]        wd3,
    output logic [ADDR_SIZE-1:0]   pc,
    output logic                   misalign_o
`ifdef XGRISCV_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0]   instret_o
`endif
);

    logic        valid_q, valid_d;
    wb_payload_t payload_q, payload_d;
    logic [XLEN-1:0] load_data;
    logic            load_mis;

    // Flush beats stall; a stalled instruction leaves a bubble and its payload parked.
    always_comb begin
        valid_d   = 1'b0;
        payload_d = payload_q;
        if (!mem.flush_i) begin
            valid_d = mem.mem_valid_i & ~mem.stall_i;
            if (!mem.stall_i) begin
                payload_d.regwr  = mem.mem_regwr_i;
                payload_d.rd     = mem.mem_rd_i;
                payload_d.wbsel  = wbsel_e'(mem.mem_wbsel_i);
                payload_d.ldtype = mem.mem_ldtype_i;
                payload_d.pc     = mem.mem_pc_i;
                payload_d.alu    = mem.mem_alu_i;
                payload_d.imm    = mem.mem_imm_i;
                payload_d.rdata  = mem.mem_rdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    load_align u_load_align (
        .rdata_i    (payload_q.rdata),
        .off_i      (payload_q.alu[1:0]),
        .ldtype_i   (payload_q.ldtype),
        .data_o     (load_data),
        .misalign_o (load_mis)
    );

    always_comb begin
        wd3 = payload_q.alu;
        unique case (payload_q.wbsel)
            WB_ALU:  wd3 = payload_q.alu;
            WB_MEM:  wd3 = load_data;
            WB_PC4:  wd3 = XLEN'(payload_q.pc + ADDR_SIZE'(4));
            WB_IMM:  wd3 = payload_q.imm;
            default: wd3 = payload_q.alu;
        endcase
        misalign_o = valid_q & (payload_q.wbsel == WB_MEM) & load_mis;
        we3        = valid_q & payload_q.regwr & (payload_q.rd != '0) & ~misalign_o;
        wa3        = payload_q.rd;
        pc         = payload_q.pc;
    end

`ifdef XGRISCV_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;

    // Every retiring instruction counts, including x0 targets and non-writing ones.
    always_comb begin
        instret_d = instret_q;
        if (valid_q && !misalign_o) begin
            instret_d = instret_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage: directed vector table, multi-cycle corner sequences and randomized traffic vs a reference model.
module tb_memwb_stage;
    import memwb_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pc;
    logic        misalign_o;
`ifdef XGRISCV_INSTRET_EN
    logic [63:0] instret_o;
`endif

    always #5 clk = ~clk;

    memwb_stage_if mif();

    memwb_stage dut (
        .clk        (clk),
        .reset      (rst),
        .mem        (mif),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .pc         (pc),
        .misalign_o (misalign_o)
`ifdef XGRISCV_INSTRET_EN
        ,
        .instret_o  (instret_o)
`endif
    );

    typedef struct {
        logic        valid;
        logic        stall;
        logic        flush;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        regwr;
        logic [1:0]  wbsel;
        logic [2:0]  ldtype;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        string       name;
        txn_t        t;
        logic        exp_we;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        logic        exp_mis;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int writes   = 0;

    logic            m_valid;
    txn_t            m_t;
    longint unsigned m_cnt;

    function automatic txn_t mk(logic v, logic s, logic f, logic [31:0] p, logic [4:0] rd, logic rw,
                                logic [1:0] ws, logic [2:0] lt, logic [31:0] a, logic [31:0] im, logic [31:0] rdat);
        txn_t t;
        t.valid = v; t.stall = s; t.flush = f; t.pc = p; t.rd = rd; t.regwr = rw;
        t.wbsel = ws; t.ldtype = lt; t.alu = a; t.imm = im; t.rdata = rdat;
        return t;
    endfunction

    function automatic logic ref_mis(txn_t t);
        int off;
        logic half_bad, word_bad;
        off      = int'(t.alu[1:0]);
        half_bad = (t.ldtype == 3'd1 || t.ldtype == 3'd5) && (off % 2 != 0);
        word_bad = !(t.ldtype inside {3'd0, 3'd1, 3'd4, 3'd5}) && (off != 0);
        return (t.wbsel == 2'd1) && (half_bad || word_bad);
    endfunction

    function automatic logic [31:0] ref_wd(txn_t t);
        int off;
        logic [31:0] b, h, ld;
        off = int'(t.alu[1:0]);
        b   = (t.rdata >> (8 * off)) & 32'hFF;
        h   = (t.rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (t.ldtype)
            3'd0:    ld = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    ld = b;
            3'd1:    ld = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd5:    ld = h;
            default: ld = t.rdata;
        endcase
        case (t.wbsel)
            2'd0:    return t.alu;
            2'd1:    return ld;
            2'd2:    return t.pc + 32'd4;
            default: return t.imm;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input txn_t t);
        mif.mem_valid_i  = t.valid;
        mif.stall_i      = t.stall;
        mif.flush_i      = t.flush;
        mif.mem_pc_i     = t.pc;
        mif.mem_rd_i     = t.rd;
        mif.mem_regwr_i  = t.regwr;
        mif.mem_wbsel_i  = t.wbsel;
        mif.mem_ldtype_i = t.ldtype;
        mif.mem_alu_i    = t.alu;
        mif.mem_imm_i    = t.imm;
        mif.mem_rdata_i  = t.rdata;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_t     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_cnt   = 0;
    endtask

    // Drive at negedge, advance one clock, update the model, compare #1 after the edge.
    task automatic cycle(input txn_t t);
        logic exp_mis;
        drive(t);
        @(posedge clk);
        if (m_valid && !ref_mis(m_t)) m_cnt++;
        if (t.flush) m_valid = 1'b0;
        else         m_valid = t.valid & ~t.stall;
        if (!t.flush && !t.stall) m_t = t;
        #1;
        exp_mis = m_valid && ref_mis(m_t);
        chk("model_we3", 64'(we3), 64'(m_valid && m_t.regwr && (m_t.rd != 0) && !exp_mis));
        chk("model_wa3", 64'(wa3), 64'(m_t.rd));
        chk("model_wd3", 64'(wd3), 64'(ref_wd(m_t)));
        chk("model_pc", 64'(pc), 64'(m_t.pc));
        chk("model_misalign", 64'(misalign_o), 64'(exp_mis));
`ifdef XGRISCV_INSTRET_EN
        chk("model_instret", instret_o, 64'(m_cnt));
`endif
        if (we3) writes++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs[$];
    txn_t idle;

    initial begin
        txn_t t;
        vec_t v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back('{"alu_rd5",     mk(1,0,0,32'h100,5,1,0,0,32'h0000_1234,0,0),            1,5,32'h0000_1234,0});
        vecs.push_back('{"alu_rd0",     mk(1,0,0,32'h104,0,1,0,0,32'h0000_1234,0,0),            0,0,32'h0000_1234,0});
        vecs.push_back('{"lb_off3",     mk(1,0,0,32'h108,7,1,1,3'd0,32'h1003,0,32'h80FF_7F01),  1,7,32'hFFFF_FF80,0});
        vecs.push_back('{"lbu_off3",    mk(1,0,0,32'h10C,7,1,1,3'd4,32'h1003,0,32'h80FF_7F01),  1,7,32'h0000_0080,0});
        vecs.push_back('{"lh_off2",     mk(1,0,0,32'h110,8,1,1,3'd1,32'h1002,0,32'h80FF_7F01),  1,8,32'hFFFF_80FF,0});
        vecs.push_back('{"lhu_off0",    mk(1,0,0,32'h114,8,1,1,3'd5,32'h1000,0,32'h80FF_7F01),  1,8,32'h0000_7F01,0});
        vecs.push_back('{"lw_mis",      mk(1,0,0,32'h118,9,1,1,3'd2,32'h1002,0,32'h80FF_7F01),  0,9,32'h80FF_7F01,1});
        vecs.push_back('{"lh_mis",      mk(1,0,0,32'h11C,9,1,1,3'd1,32'h1001,0,32'h80FF_7F01),  0,9,32'h0000_7F01,1});
        vecs.push_back('{"lw_rsvd",     mk(1,0,0,32'h120,4,1,1,3'd3,32'h1000,0,32'h1234_5678),  1,4,32'h1234_5678,0});
        vecs.push_back('{"jal_wrap",    mk(1,0,0,32'hFFFF_FFFC,1,1,2,0,0,0,0),                  1,1,32'h0000_0000,0});
        vecs.push_back('{"lui",         mk(1,0,0,32'h124,2,1,3,0,0,32'hABCD_E000,0),            1,2,32'hABCD_E000,0});
        vecs.push_back('{"invalid_lw",  mk(0,0,0,32'h128,6,1,1,3'd2,32'h1002,0,32'h5555_AAAA),  0,6,32'h5555_AAAA,0});
        vecs.push_back('{"no_regwr",    mk(1,0,0,32'h12C,3,0,0,0,32'hDEAD_BEEF,0,0),            0,3,32'hDEAD_BEEF,0});

        rst = 1'b1;
        drive(idle);
        model_reset();
        #12;
        chk("reset_we3", 64'(we3), 64'd0);
        chk("reset_wa3", 64'(wa3), 64'd0);
        chk("reset_wd3", 64'(wd3), 64'd0);
        chk("reset_pc", 64'(pc), 64'd0);
        chk("reset_misalign", 64'(misalign_o), 64'd0);
`ifdef XGRISCV_INSTRET_EN
        chk("reset_instret", instret_o, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.t);
            cycle(v.t);
            // cycle() leaves us at the following negedge; outputs are stable there
            chk({v.name, "_we3"}, 64'(we3), 64'(v.exp_we));
            chk({v.name, "_wa3"}, 64'(wa3), 64'(v.exp_wa));
            chk({v.name, "_wd3"}, 64'(wd3), 64'(v.exp_wd));
            chk({v.name, "_pc"}, 64'(pc), 64'(v.t.pc));
            chk({v.name, "_mis"}, 64'(misalign_o), 64'(v.exp_mis));
        end

        // Asynchronous reset while a valid write is sitting in WB.
        t = mk(1,0,0,32'h200,5,1,0,0,32'h0000_1234,0,0);
        cycle(t);
        chk("pre_reset_we3", 64'(we3), 64'd1);
        drive(idle);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_we3", 64'(we3), 64'd0);
        chk("async_reset_wd3", 64'(wd3), 64'd0);
        chk("async_reset_pc", 64'(pc), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Three stalled cycles then release: exactly one write.
        writes = 0;
        t = mk(1,1,0,32'h300,9,1,0,0,32'h0000_0099,0,0);
        for (int i = 0; i < 3; i++) cycle(t);
        t.stall = 1'b0;
        cycle(t);
        cycle(idle);
        cycle(idle);
        chk("stall_single_write", 64'(writes), 64'd1);

        // Flush together with stall: bubble only.
        writes = 0;
        t = mk(1,1,1,32'h400,10,1,0,0,32'h0000_0077,0,0);
        cycle(t);
        cycle(idle);
        chk("flush_stall_no_write", 64'(writes), 64'd0);

`ifdef XGRISCV_INSTRET_EN
        do_reset();
        for (int i = 0; i < 10; i++) begin
            t = mk(1,0,0,32'h500 + 32'(4*i),5'(i),1,0,0,32'(i),0,0);
            cycle(t);
        end
        cycle(idle);
        chk("instret_ten", instret_o, 64'd10);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [2:0] lts [6];
            lts = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
            t.valid  = ($urandom_range(0, 9) < 7);
            t.stall  = ($urandom_range(0, 9) < 2);
            t.flush  = ($urandom_range(0, 9) < 1);
            t.pc     = $urandom();
            t.rd     = 5'($urandom());
            t.regwr  = ($urandom_range(0, 9) < 8);
            t.wbsel  = 2'($urandom());
            t.ldtype = lts[$urandom_range(0, 5)];
            t.alu    = $urandom();
            t.imm    = $urandom();
            t.rdata  = $urandom();
            cycle(t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
